// File: rtl/uart_host_drv.sv
// uart_host_drv: polls a register-mapped UART and moves bytes between a
// valid/ready byte stream and the UART TDR/RDR registers.
`ifndef UART_MUX_CTRL
`define UART_MUX_CTRL 3'd0
`define UART_MUX_STAT 3'd1
`define UART_MUX_TDR  3'd2
`define UART_MUX_RDR  3'd3
`define UART_MUX_BAUD 3'd4
`endif

module uart_host_drv #(
  parameter logic [31:0] BAUD_DIV      = 32'd0,
  parameter logic [15:0] START_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_err,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        bus_we,
  output logic [2:0]  bus_reg_num,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rd,
  output logic        busy,
  output logic [3:0]  dbg_state
);

  // Handshakes: a byte moves when valid and ready are both high at a rising
  // edge; a producer holds valid and data stable until that edge.
  typedef enum logic [3:0] {
    CFG        = 4'd0,
    IDLE       = 4'd1,
    RD_STAT    = 4'd2,
    WT_STAT    = 4'd3,
    EVAL       = 4'd4,
    WR_TDR     = 4'd5,
    WR_CTRL    = 4'd6,
    TX_WAIT_HI = 4'd7,
    TX_WAIT_LO = 4'd8,
    RD_RDR     = 4'd9,
    WT_RDR     = 4'd10
  } state_t;

  state_t      state_q, state_d;
  logic        cfg_done_q, cfg_done_d;
  logic        poll_ph_q, poll_ph_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        stat_rxne_q, stat_rxne_d;
  logic        stat_txbusy_q, stat_txbusy_d;
  logic        bus_we_q, bus_we_d;
  logic [2:0]  bus_reg_num_q, bus_reg_num_d;
  logic [31:0] bus_wd_q, bus_wd_d;
  logic        tx_ready_q, tx_ready_d;
  logic        tx_err_q, tx_err_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        busy_q, busy_d;
  logic        unused_bus_rd;

  assign unused_bus_rd = ^bus_rd[30:8];

  always_comb begin
    state_d       = state_q;
    cfg_done_d    = cfg_done_q;
    poll_ph_d     = poll_ph_q;
    to_cnt_d      = to_cnt_q;
    stat_rxne_d   = stat_rxne_q;
    stat_txbusy_d = stat_txbusy_q;
    rx_valid_d    = rx_valid_q;
    rx_data_d     = rx_data_q;
    tx_err_d      = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      CFG: begin
        // First cycle after reset loads the BAUD write, second cycle drives it.
        if (cfg_done_q) state_d = IDLE;
        else            cfg_done_d = 1'b1;
      end
      IDLE:    state_d = RD_STAT;
      RD_STAT: state_d = WT_STAT;
      WT_STAT: begin
        stat_rxne_d   = bus_rd[31];
        stat_txbusy_d = bus_rd[1];
        state_d       = EVAL;
      end
      EVAL: begin
        if (stat_rxne_q && !rx_valid_q)      state_d = RD_RDR;
        else if (tx_valid && !stat_txbusy_q) state_d = WR_TDR;
        else                                 state_d = IDLE;
      end
      WR_TDR: state_d = WR_CTRL;
      WR_CTRL: begin
        state_d   = TX_WAIT_HI;
        poll_ph_d = 1'b0;
        to_cnt_d  = 16'd0;
      end
      TX_WAIT_HI: begin
        // poll_ph_q=1 marks the cycle where the previous STAT read lands.
        poll_ph_d = ~poll_ph_q;
        to_cnt_d  = to_cnt_q + 16'd1;
        if (poll_ph_q && bus_rd[1]) begin
          state_d   = TX_WAIT_LO;
          poll_ph_d = 1'b0;
        end else if (to_cnt_d >= START_TIMEOUT) begin
          state_d  = IDLE;
          tx_err_d = 1'b1;
        end
      end
      TX_WAIT_LO: begin
        poll_ph_d = ~poll_ph_q;
        if (poll_ph_q && !bus_rd[1]) state_d = IDLE;
      end
      RD_RDR: state_d = WT_RDR;
      WT_RDR: begin
        rx_data_d  = bus_rd[7:0];
        rx_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = CFG;
    endcase

    // Bus outputs are registered for the state being entered.
    bus_we_d      = 1'b0;
    bus_reg_num_d = `UART_MUX_STAT;
    bus_wd_d      = 32'd0;
    tx_ready_d    = 1'b0;
    case (state_d)
      CFG: begin
        bus_we_d      = 1'b1;
        bus_reg_num_d = `UART_MUX_BAUD;
        bus_wd_d      = BAUD_DIV;
      end
      WR_TDR: begin
        bus_we_d      = 1'b1;
        bus_reg_num_d = `UART_MUX_TDR;
        bus_wd_d      = {24'd0, tx_data};
        tx_ready_d    = 1'b1;
      end
      WR_CTRL: begin
        bus_we_d      = 1'b1;
        bus_reg_num_d = `UART_MUX_CTRL;
        bus_wd_d      = 32'd1;
      end
      RD_RDR:  bus_reg_num_d = `UART_MUX_RDR;
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CFG;
      cfg_done_q    <= 1'b0;
      poll_ph_q     <= 1'b0;
      to_cnt_q      <= 16'd0;
      stat_rxne_q   <= 1'b0;
      stat_txbusy_q <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_reg_num_q <= 3'd0;
      bus_wd_q      <= 32'd0;
      tx_ready_q    <= 1'b0;
      tx_err_q      <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= 8'd0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cfg_done_q    <= cfg_done_d;
      poll_ph_q     <= poll_ph_d;
      to_cnt_q      <= to_cnt_d;
      stat_rxne_q   <= stat_rxne_d;
      stat_txbusy_q <= stat_txbusy_d;
      bus_we_q      <= bus_we_d;
      bus_reg_num_q <= bus_reg_num_d;
      bus_wd_q      <= bus_wd_d;
      tx_ready_q    <= tx_ready_d;
      tx_err_q      <= tx_err_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      busy_q        <= busy_d;
    end
  end

  assign bus_we      = bus_we_q;
  assign bus_reg_num = bus_reg_num_q;
  assign bus_wd      = bus_wd_q;
  assign tx_ready    = tx_ready_q;
  assign tx_err      = tx_err_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule
